// File: rtl/ofs_fim_arb_pkg.sv
// Shared types and helpers for the AFU TX round-robin arbiter.
// Holds the arbiter state type and the rotating-priority pick function.
package ofs_fim_arb_pkg;

  localparam int DEF_NUM_PORTS = 4;
  localparam int DEF_DATA_W    = 512;
  localparam int DEF_USER_W    = 10;
  localparam int MAX_PORTS     = 16;

  typedef enum logic {
    ARB = 1'b0,
    PKT = 1'b1
  } arb_state_e;

  // First set bit of elig searching upward from last+1, wrapping modulo n.
  function automatic logic [3:0] rr_pick(
    input logic [15:0] elig,
    input logic [3:0]  last,
    input int          n
  );
    logic [3:0] g;
    logic       hit;
    int         idx;
    g   = '0;
    hit = 1'b0;
    for (int k = 1; k <= MAX_PORTS; k++) begin
      idx = (int'(last) + k) % n;
      if (k <= n && !hit && elig[idx]) begin
        g   = 4'(idx);
        hit = 1'b1;
      end
    end
    return g;
  endfunction

endpackage

// File: rtl/axis_skid_buf.sv
// Two-entry AXI-Stream register slice with a registered space flag,
// so upstream ready never combinationally depends on m_tready.
module axis_skid_buf #(
  parameter int DATA_W = 512,
  parameter int KEEP_W = DATA_W / 8,
  parameter int USER_W = 10
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              s_tvalid,
  output logic              in_rdy,
  input  logic [DATA_W-1:0] s_tdata,
  input  logic [KEEP_W-1:0] s_tkeep,
  input  logic [USER_W-1:0] s_tuser,
  input  logic              s_tlast,
  output logic              m_tvalid,
  input  logic              m_tready,
  output logic [DATA_W-1:0] m_tdata,
  output logic [KEEP_W-1:0] m_tkeep,
  output logic [USER_W-1:0] m_tuser,
  output logic              m_tlast
);

  localparam int W = DATA_W + KEEP_W + USER_W + 1;

  logic [W-1:0] e0_q, e0_d;
  logic [W-1:0] e1_q, e1_d;
  logic [1:0]   cnt_q, cnt_d;
  logic         in_rdy_q, in_rdy_d;
  logic [W-1:0] din;
  logic         push, pop;

  always_comb begin
    din  = {s_tdata, s_tkeep, s_tuser, s_tlast};
    push = s_tvalid & in_rdy_q;
    pop  = m_tready & (cnt_q != 2'd0);
    e0_d = e0_q;
    e1_d = e1_q;
    cnt_d = cnt_q;
    case (cnt_q)
      2'd0: begin
        if (push) begin
          e0_d  = din;
          cnt_d = 2'd1;
        end
      end
      2'd1: begin
        if (push && pop) begin
          e0_d = din;
        end else if (push) begin
          e1_d  = din;
          cnt_d = 2'd2;
        end else if (pop) begin
          cnt_d = 2'd0;
        end
      end
      2'd2: begin
        if (pop) begin
          e0_d  = e1_q;
          cnt_d = 2'd1;
        end
      end
      default: cnt_d = 2'd0;
    endcase
    in_rdy_d = (cnt_d != 2'd2);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e0_q     <= '0;
      e1_q     <= '0;
      cnt_q    <= 2'd0;
      in_rdy_q <= 1'b0;
    end else begin
      e0_q     <= e0_d;
      e1_q     <= e1_d;
      cnt_q    <= cnt_d;
      in_rdy_q <= in_rdy_d;
    end
  end

  assign in_rdy   = in_rdy_q;
  assign m_tvalid = (cnt_q != 2'd0);
  assign {m_tdata, m_tkeep, m_tuser, m_tlast} = e0_q;

endmodule

// File: rtl/afu_tx_rr_arb.sv
// Packet-granular round-robin arbiter sharing one TX AXI-S channel
// between NUM_PORTS AFU sources; grant is held from first beat to tlast.
module afu_tx_rr_arb
  import ofs_fim_arb_pkg::*;
#(
  parameter int NUM_PORTS = DEF_NUM_PORTS,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int USER_W    = DEF_USER_W,
  parameter int KEEP_W    = DATA_W / 8,
  parameter int PORT_W    = $clog2(NUM_PORTS)
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_PORTS-1:0]        port_en,
  input  logic [NUM_PORTS-1:0]        s_tvalid,
  output logic [NUM_PORTS-1:0]        s_tready,
  input  logic [NUM_PORTS*DATA_W-1:0] s_tdata,
  input  logic [NUM_PORTS*KEEP_W-1:0] s_tkeep,
  input  logic [NUM_PORTS*USER_W-1:0] s_tuser,
  input  logic [NUM_PORTS-1:0]        s_tlast,
  output logic                        m_tvalid,
  input  logic                        m_tready,
  output logic [DATA_W-1:0]           m_tdata,
  output logic [KEEP_W-1:0]           m_tkeep,
  output logic [USER_W-1:0]           m_tuser,
  output logic                        m_tlast,
  output logic [PORT_W-1:0]           grant_idx,
  output logic                        busy
);

  arb_state_e  state_q, state_d;
  logic [PORT_W-1:0] cur_q, cur_d;
  logic [PORT_W-1:0] last_grant_q, last_grant_d;
  logic [PORT_W-1:0] grant_idx_q, grant_idx_d;

  logic [NUM_PORTS-1:0] elig;
  logic [PORT_W-1:0]    pick, sel;
  logic                 buf_rdy, take, fire;
  logic [DATA_W-1:0]    f_data;
  logic [KEEP_W-1:0]    f_keep;
  logic [USER_W-1:0]    f_user;
  logic                 f_last;

  always_comb begin
    elig = s_tvalid & port_en;
    pick = PORT_W'(rr_pick(16'(elig), 4'(last_grant_q), NUM_PORTS));
    sel  = (state_q == PKT) ? cur_q : pick;
    // In PKT the owner is served regardless of port_en or other valids.
    take = buf_rdy & ((state_q == PKT) | (|elig));
    s_tready = take ? (NUM_PORTS'(1) << sel) : '0;
    fire = take & s_tvalid[sel];

    f_data = '0;
    f_keep = '0;
    f_user = '0;
    f_last = 1'b0;
    for (int i = 0; i < NUM_PORTS; i++) begin
      if (sel == PORT_W'(i)) begin
        f_data = s_tdata[i*DATA_W +: DATA_W];
        f_keep = s_tkeep[i*KEEP_W +: KEEP_W];
        f_user = s_tuser[i*USER_W +: USER_W];
        f_last = s_tlast[i];
      end
    end

    state_d      = state_q;
    cur_d        = cur_q;
    last_grant_d = last_grant_q;
    grant_idx_d  = grant_idx_q;
    unique case (state_q)
      ARB: begin
        if (fire) begin
          grant_idx_d = sel;
          if (f_last) begin
            last_grant_d = sel;
          end else begin
            state_d = PKT;
            cur_d   = sel;
          end
        end
      end
      PKT: begin
        if (fire && f_last) begin
          state_d      = ARB;
          last_grant_d = cur_q;
        end
      end
      default: state_d = ARB;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ARB;
      cur_q        <= '0;
      last_grant_q <= PORT_W'(NUM_PORTS - 1);
      grant_idx_q  <= '0;
    end else begin
      state_q      <= state_d;
      cur_q        <= cur_d;
      last_grant_q <= last_grant_d;
      grant_idx_q  <= grant_idx_d;
    end
  end

  axis_skid_buf #(
    .DATA_W (DATA_W),
    .KEEP_W (KEEP_W),
    .USER_W (USER_W)
  ) u_skid (
    .clk      (clk),
    .rst_n    (rst_n),
    .s_tvalid (fire),
    .in_rdy   (buf_rdy),
    .s_tdata  (f_data),
    .s_tkeep  (f_keep),
    .s_tuser  (f_user),
    .s_tlast  (f_last),
    .m_tvalid (m_tvalid),
    .m_tready (m_tready),
    .m_tdata  (m_tdata),
    .m_tkeep  (m_tkeep),
    .m_tuser  (m_tuser),
    .m_tlast  (m_tlast)
  );

  assign grant_idx = grant_idx_q;
  assign busy      = (state_q == PKT) | m_tvalid;

endmodule

// File: doc/afu_tx_rr_arb.md
Name: afu_tx_rr_arb

Overview:
- Packet-granular round-robin arbiter that shares one PCIe SS TX AXI-Stream channel between NUM_PORTS AFU TX sources, for example several static-region endpoints feeding one TX A or TX B path.
- Grant is locked for the whole packet, from first beat to the tlast beat, so packets are never interleaved.
- A per-port enable removes a port from arbitration at packet boundaries; this is used during FLR/port reset.
- Output is registered through a 2-entry skid buffer, giving full throughput and no combinational path from m_tready to s_tready.

Parameters:
- NUM_PORTS, 4: number of requesting sources; legal range 2..16.
- DATA_W, 512: TDATA width.
- USER_W, 10: TUSER width (PCIe SS tuser_vendor).
- KEEP_W, DATA_W/8: TKEEP width.
- PORT_W, $clog2(NUM_PORTS): width of the grant index.

Ports:
- clk  in  1  single clock for all logic.
- rst_n  in  1  asynchronous, active-low reset; deassertion is synchronous to clk upstream.
- port_en  in  NUM_PORTS  1 = port may win arbitration; sampled only when choosing a new grant.
- s_tvalid  in  NUM_PORTS  per-port valid.
- s_tready  out  NUM_PORTS  per-port ready.
- s_tdata  in  NUM_PORTS*DATA_W  packed; port i occupies slice [i*DATA_W +: DATA_W].
- s_tkeep  in  NUM_PORTS*KEEP_W  packed, same slicing.
- s_tuser  in  NUM_PORTS*USER_W  packed, same slicing.
- s_tlast  in  NUM_PORTS  per-port last.
- m_tvalid  out  1  output valid.
- m_tready  in  1  output ready.
- m_tdata  out  DATA_W  output data.
- m_tkeep  out  KEEP_W  output keep.
- m_tuser  out  USER_W  output user.
- m_tlast  out  1  output last.
- grant_idx  out  PORT_W  port currently or most recently granted.
- busy  out  1  1 while in PKT state or while the skid buffer is non-empty.

Behaviour:
- Reset values (asynchronous): state = ARB; last_grant = NUM_PORTS-1, so port 0 has first priority; skid buffer empty; m_tvalid = 0; s_tready = 0; grant_idx = 0; busy = 0. Data outputs are don't-care while m_tvalid = 0.
- Eligibility: elig[i] = s_tvalid[i] & port_en[i].
- State ARB:
  - If buf_rdy = 1 and elig != 0, pick the first set bit of elig, searching upward from (last_grant+1) and wrapping modulo NUM_PORTS.
  - Accept that port's beat in the same cycle: s_tready[g] = 1; all other s_tready = 0.
  - grant_idx <= g.
  - If the accepted beat has tlast = 0, go to PKT with cur = g.
  - If tlast = 1 (single-beat packet), stay in ARB and set last_grant <= g.
  - If no port is eligible, or buf_rdy = 0, all s_tready = 0.
- State PKT:
  - s_tready[cur] = buf_rdy; all other s_tready = 0.
  - port_en[cur] is ignored; a packet is never truncated.
  - When a beat with tlast = 1 is accepted, go to ARB and set last_grant <= cur.
  - A new grant can be issued in the cycle after tlast is accepted, so the inter-packet bubble is 1 cycle at most.
  - Single-beat back-to-back packets from different ports sustain 1 beat/cycle.
- Handshake rules:
  - s_tready never depends on s_tvalid of any other port once in PKT.
  - No combinational path from m_tready to any s_tready; buf_rdy is a registered "buffer has space" flag.
  - m_* is AXI-S compliant: once m_tvalid = 1, m_* stays stable until m_tready = 1.
- Latency: a beat accepted on an input in cycle t appears on m_* in cycle t+1 when the buffer was empty.
- Throughput: 1 beat/cycle with m_tready held at 1.
- Skid buffer boundary conditions:
  - Full (2 entries): buf_rdy = 0 and all s_tready = 0.
  - m_tready low for N cycles: data is held; nothing is lost or duplicated.
  - Simultaneous push and pop while full is impossible, because buf_rdy = 0.
- Priority and fairness:
  - last_grant advances only at packet end, so every eligible port is served within NUM_PORTS packets.
  - A port whose port_en falls while it is waiting is skipped.
  - A port whose port_en rises is considered at the next ARB decision.
- Reset mid-packet: all state and the buffer are cleared immediately. Any partial packet on m_* is abandoned. Upstream ports are required to be in reset at the same time.

Decomposition:
- Shared package (ofs_fim_arb_pkg):
  - typedef of the state enum {ARB, PKT}.
  - function rr_pick(elig, last) returning the grant index.
  - localparams for default widths.
- One sub-module: axis_skid_buf, a 2-entry AXI-S register slice with parameters DATA_W/KEEP_W/USER_W, ports clk/rst_n, s_*/m_*, and a registered in_rdy output.

Test Plan:
- Reset then ports 0-3 each present one single-beat packet continuously with m_tready = 1 -> output order 0,1,2,3,0,1,... with m_tvalid = 1 every cycle from cycle 2.
- Port 1 sends a 4-beat packet while port 2 is valid -> port 2 is blocked for all 4 beats; the first port 2 beat appears on m_* exactly after port 1's tlast; no interleaving.
- port_en[2] dropped while port 2 is mid-packet (beat 2 of 5) -> all 5 beats complete; port 2 is not granted again until port_en[2] = 1.
- m_tready held at 0 for 10 cycles during a 3-beat packet -> at most 2 beats are buffered, s_tready = 0, and the beats emerge in order with no loss.
- rst_n asserted in the middle of a packet, then released -> m_tvalid = 0 immediately, grant_idx = 0, and the first new grant goes to port 0 when all ports are valid.
- Only port 3 is eligible, with last_grant = 3 -> the wrap-around search grants port 3 again with no bubble between packets beyond 1 cycle.
